computation_sequencer: RTL and testbench

- Initiator-side controller for computation_module.
- Latches a 4x4 operand A (8-bit) and a 3x3 kernel B (8-bit) on start and drives them onto the module's a*/b* inputs.
- Issues active_store, then one or all of the active_single / active_sa3 / active_sa2 requests. Each active is held until its done_* returns.
- Captures c11..c22 per compute mode and reports it to the host with a valid pulse; sits between the host/top-level FSM and computation_module.

---
 rtl/comp_pkg.sv | 39 +++
 rtl/comp_req_timer.sv | 45 ++++
 rtl/computation_sequencer.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_computation_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/comp_pkg.sv
// -----------------------------------------------------------------------------
// comp_pkg
// Shared definitions for computation_sequencer and its request timer:
//   - operand packing widths (DATA_W, A_W, B_W)
//   - compute-mode encodings (MODE_SINGLE / MODE_SA3 / MODE_SA2 / MODE_ALL)
//   - sequencer state encodings (IDLE / STORE / GAP / RUN / FIN)
//   - next_tag(): order of compute requests when all three modes run
// -----------------------------------------------------------------------------
package comp_pkg;

  localparam int DATA_W = 8;
  localparam int A_W    = 16 * DATA_W;  // 4x4 operand, a11 in the low byte
  localparam int B_W    = 9 * DATA_W;   // 3x3 kernel, b11 in the low byte

  typedef enum logic [1:0] {
    MODE_SINGLE = 2'b00,
    MODE_SA3    = 2'b01,
    MODE_SA2    = 2'b10,
    MODE_ALL    = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    STORE = 3'd1,
    GAP   = 3'd2,
    RUN   = 3'd3,
    FIN   = 3'd4
  } state_e;

  // Request order for MODE_ALL: single -> sa3 -> sa2.
  function automatic mode_e next_tag(input mode_e tag);
    case (tag)
      MODE_SINGLE: return MODE_SA3;
      MODE_SA3:    return MODE_SA2;
      default:     return MODE_SA2;
    endcase
  endfunction

endpackage

// File: rtl/comp_req_timer.sv
// -----------------------------------------------------------------------------
// comp_req_timer
// Loadable down-counter shared by the sequencer for the inter-request gap and
// the per-request watchdog. Counts down to zero and holds there.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset (count -> 0)
//   load_i     load load_val_i (takes priority over en_i)
//   load_val_i value to load
//   en_i       decrement enable
//   expired_o  count is zero
// -----------------------------------------------------------------------------
module comp_req_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/computation_sequencer.sv
// -----------------------------------------------------------------------------
// computation_sequencer
// Initiator-side controller for computation_module. On start it latches the
// A operand and B kernel, issues active_store, then one compute request (or
// single -> sa3 -> sa2 for mode 11), holding each active until its done
// returns, and reports each captured result with a one-cycle res_valid.
//
// Optional build macro COMP_SEQ_TIMEOUT_EN: adds a per-request watchdog of
// TIMEOUT_CYCLES; on expiry the request is abandoned, err is set and the
// sequence finishes without res_valid. Without it err is tied 0.
//
// Ports:
//   clk, rst                    clock / asynchronous active-high reset
//   start, mode, a_in, b_in     host request (sampled in IDLE only)
//   a_bus, b_bus                registered operands to computation_module
//   active_store/single/sa3/sa2 requests to computation_module
//   done_store/single/sa3/sa2   completions from computation_module
//   c11, c12, c21, c22          results from computation_module
//   res, res_mode, res_valid    captured result, its mode tag, valid pulse
//   busy, done, err             sequence status
// -----------------------------------------------------------------------------
module computation_sequencer
  import comp_pkg::*;
#(
  parameter int GAP_CYCLES     = 3,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [A_W-1:0]    a_in,
  input  logic [B_W-1:0]    b_in,
  output logic [A_W-1:0]    a_bus,
  output logic [B_W-1:0]    b_bus,
  output logic              active_store,
  output logic              active_single,
  output logic              active_sa3,
  output logic              active_sa2,
  input  logic              done_store,
  input  logic              done_single,
  input  logic              done_sa3,
  input  logic              done_sa2,
  input  logic [DATA_W-1:0] c11,
  input  logic [DATA_W-1:0] c12,
  input  logic [DATA_W-1:0] c21,
  input  logic [DATA_W-1:0] c22,
  output logic [31:0]       res,
  output logic [1:0]        res_mode,
  output logic              res_valid,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int          TMR_W    = 16;
  // The timer counts down to zero inclusive, so load one less than the span.
  localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP_CYCLES - 1);
  localparam logic [TMR_W-1:0] TO_LOAD  = TMR_W'(TIMEOUT_CYCLES - 1);

  state_e          state_q, state_d;
  mode_e           cur_mode_q, cur_mode_d;
  mode_e           tag_q, tag_d;
  logic [A_W-1:0]  a_bus_q, a_bus_d;
  logic [B_W-1:0]  b_bus_q, b_bus_d;
  logic            act_store_q, act_store_d;
  logic            act_single_q, act_single_d;
  logic            act_sa3_q, act_sa3_d;
  logic            act_sa2_q, act_sa2_d;
  logic [31:0]     res_q, res_d;
  logic [1:0]      res_mode_q, res_mode_d;
  logic            res_valid_q, res_valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_en;
  logic             tmr_expired;
  logic             timeout_hit;
  logic             req_done;

  comp_req_timer #(
    .CNT_W (TMR_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .expired_o  (tmr_expired)
  );

`ifdef COMP_SEQ_TIMEOUT_EN
  logic err_q, err_d;
  // In STORE/RUN the timer always holds the watchdog count.
  assign timeout_hit = tmr_expired;
  assign err         = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  // Completion that matches the compute request currently in flight.
  always_comb begin
    case (tag_q)
      MODE_SINGLE: req_done = done_single;
      MODE_SA3:    req_done = done_sa3;
      default:     req_done = done_sa2;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cur_mode_d   = cur_mode_q;
    tag_d        = tag_q;
    a_bus_d      = a_bus_q;
    b_bus_d      = b_bus_q;
    act_store_d  = act_store_q;
    act_single_d = act_single_q;
    act_sa3_d    = act_sa3_q;
    act_sa2_d    = act_sa2_q;
    res_d        = res_q;
    res_mode_d   = res_mode_q;
    res_valid_d  = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    tmr_load     = 1'b0;
    tmr_val      = TO_LOAD;
    tmr_en       = 1'b0;
`ifdef COMP_SEQ_TIMEOUT_EN
    err_d        = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          a_bus_d     = a_in;
          b_bus_d     = b_in;
          cur_mode_d  = mode_e'(mode);
          tag_d       = (mode == MODE_ALL) ? MODE_SINGLE : mode_e'(mode);
          busy_d      = 1'b1;
          act_store_d = 1'b1;
          tmr_load    = 1'b1;
          state_d     = STORE;
`ifdef COMP_SEQ_TIMEOUT_EN
          err_d       = 1'b0;
`endif
        end
      end

      STORE: begin
        tmr_en = 1'b1;
        if (done_store) begin
          act_store_d = 1'b0;
          tmr_load    = 1'b1;
          tmr_val     = GAP_LOAD;
          state_d     = GAP;
        end else if (timeout_hit) begin
          act_store_d = 1'b0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          state_d     = FIN;
`ifdef COMP_SEQ_TIMEOUT_EN
          err_d       = 1'b1;
`endif
        end
      end

      GAP: begin
        tmr_en = 1'b1;
        // Last gap cycle: raise the next request so it is visible right after.
        if (tmr_expired) begin
          act_single_d = (tag_q == MODE_SINGLE);
          act_sa3_d    = (tag_q == MODE_SA3);
          act_sa2_d    = (tag_q == MODE_SA2);
          tmr_load     = 1'b1;
          state_d      = RUN;
        end
      end

      RUN: begin
        tmr_en = 1'b1;
        if (req_done) begin
          act_single_d = 1'b0;
          act_sa3_d    = 1'b0;
          act_sa2_d    = 1'b0;
          res_d        = {c22, c21, c12, c11};
          res_mode_d   = tag_q;
          res_valid_d  = 1'b1;
          if ((cur_mode_q == MODE_ALL) && (tag_q != MODE_SA2)) begin
            tag_d    = next_tag(tag_q);
            tmr_load = 1'b1;
            tmr_val  = GAP_LOAD;
            state_d  = GAP;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = FIN;
          end
        end else if (timeout_hit) begin
          act_single_d = 1'b0;
          act_sa3_d    = 1'b0;
          act_sa2_d    = 1'b0;
          busy_d       = 1'b0;
          done_d       = 1'b1;
          state_d      = FIN;
`ifdef COMP_SEQ_TIMEOUT_EN
          err_d        = 1'b1;
`endif
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cur_mode_q   <= MODE_SINGLE;
      tag_q        <= MODE_SINGLE;
      a_bus_q      <= '0;
      b_bus_q      <= '0;
      act_store_q  <= 1'b0;
      act_single_q <= 1'b0;
      act_sa3_q    <= 1'b0;
      act_sa2_q    <= 1'b0;
      res_q        <= '0;
      res_mode_q   <= '0;
      res_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_mode_q   <= cur_mode_d;
      tag_q        <= tag_d;
      a_bus_q      <= a_bus_d;
      b_bus_q      <= b_bus_d;
      act_store_q  <= act_store_d;
      act_single_q <= act_single_d;
      act_sa3_q    <= act_sa3_d;
      act_sa2_q    <= act_sa2_d;
      res_q        <= res_d;
      res_mode_q   <= res_mode_d;
      res_valid_q  <= res_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

`ifdef COMP_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`endif

  assign a_bus         = a_bus_q;
  assign b_bus         = b_bus_q;
  assign active_store  = act_store_q;
  assign active_single = act_single_q;
  assign active_sa3    = act_sa3_q;
  assign active_sa2    = act_sa2_q;
  assign res           = res_q;
  assign res_mode      = res_mode_q;
  assign res_valid     = res_valid_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_computation_sequencer.sv
// -----------------------------------------------------------------------------
// tb_computation_sequencer
// Directed bench for computation_sequencer. The bench plays computation_module:
// it waits for each active_*, returns the matching done_* after a programmed
// number of cycles and drives the c* results. Timeout scenario only runs when
// COMP_SEQ_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_computation_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   mode;
  logic [127:0] a_in;
  logic [71:0]  b_in;
  logic [127:0] a_bus;
  logic [71:0]  b_bus;
  logic         active_store, active_single, active_sa3, active_sa2;
  logic         done_store, done_single, done_sa3, done_sa2;
  logic [7:0]   c11, c12, c21, c22;
  logic [31:0]  res;
  logic [1:0]   res_mode;
  logic         res_valid, busy, done, err;

  int checks = 0;
  int errors = 0;

  logic [127:0] a1, a2;
  logic [71:0]  b1, b2;

  computation_sequencer #(
    .GAP_CYCLES     (3),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .mode          (mode),
    .a_in          (a_in),
    .b_in          (b_in),
    .a_bus         (a_bus),
    .b_bus         (b_bus),
    .active_store  (active_store),
    .active_single (active_single),
    .active_sa3    (active_sa3),
    .active_sa2    (active_sa2),
    .done_store    (done_store),
    .done_single   (done_single),
    .done_sa3      (done_sa3),
    .done_sa2      (done_sa2),
    .c11           (c11),
    .c12           (c12),
    .c21           (c21),
    .c22           (c22),
    .res           (res),
    .res_mode      (res_mode),
    .res_valid     (res_valid),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Request index: 0 store, 1 single, 2 sa3, 3 sa2.
  function automatic logic act(input int w);
    case (w)
      0:       return active_store;
      1:       return active_single;
      2:       return active_sa3;
      default: return active_sa2;
    endcase
  endfunction

  function automatic int n_act();
    return int'(active_store) + int'(active_single) + int'(active_sa3) + int'(active_sa2);
  endfunction

  task automatic set_done(input int w, input logic v);
    case (w)
      0:       done_store  = v;
      1:       done_single = v;
      2:       done_sa3    = v;
      default: done_sa2    = v;
    endcase
  endtask

  // Start a sequence; returns at the first negedge after acceptance.
  task automatic do_start(input logic [1:0] m, input logic [127:0] a, input logic [71:0] b);
    mode  = m;
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_in  = ~a;   // later changes must not reach the buses
    b_in  = ~b;
    chk("start_busy", busy, 1'b1);
    chk("start_active_store", active_store, 1'b1);
    chk("start_a_bus", a_bus, a);
    chk("start_b_bus", b_bus, b);
  endtask

  // Serve one request: expect exp_gap idle cycles (skip if <0), hold done off
  // for n active cycles, return done on cycle n+1, then check the aftermath.
  task automatic serve(input int w, input int n, input int exp_gap, input logic [31:0] cres,
                       input logic [1:0] tag, input bit last, input bit inject);
    int gap = 0;
    while (!act(w) && gap < 60) begin
      chk("gap_no_active", n_act(), 0);
      gap++;
      @(negedge clk);
    end
    chk("req_seen", act(w), 1'b1);
    if (exp_gap >= 0) chk("gap_len", gap, exp_gap);
    if (act(w)) begin
      for (int len = 1; len <= n + 1; len++) begin
        chk("req_held", act(w), 1'b1);
        chk("one_active", n_act(), 1);
        if (len == n + 1) begin
          set_done(w, 1'b1);
          if (w != 0) {c22, c21, c12, c11} = cres;
        end
        if (inject && len == 5) begin
          start    = 1'b1;
          done_sa2 = 1'b1;
        end
        @(negedge clk);
        if (inject && len == 5) begin
          start    = 1'b0;
          done_sa2 = 1'b0;
        end
      end
      set_done(w, 1'b0);
      $display("req %0d: held %0d cycles, gap %0d", w, n + 1, gap);
      chk("req_drop", act(w), 1'b0);
      chk("res_valid", res_valid, (w != 0));
      if (w != 0) begin
        chk("res", res, cres);
        chk("res_mode", res_mode, tag);
      end
      chk("seq_done", done, last);
      chk("seq_busy", busy, !last);
    end
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b1;   // must be ignored while in reset
    mode        = 2'b00;
    a_in        = '0;
    b_in        = '0;
    done_store  = 1'b0;
    done_single = 1'b0;
    done_sa3    = 1'b0;
    done_sa2    = 1'b0;
    {c22, c21, c12, c11} = 32'h0;

    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        a1[8*(4*r+c) +: 8] = 8'(c + 1);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        b1[8*(3*r+c) +: 8] = 8'(r + 1);
    a2 = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
    b2 = 72'h99_8877_6655_4433_2211;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_actives", n_act(), 0);
    chk("rst_a_bus", a_bus, 128'h0);
    chk("rst_b_bus", b_bus, 72'h0);
    chk("rst_res", res, 32'h0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);
    chk("idle_store", active_store, 1'b0);

    // Single mode, known operands
    do_start(2'b00, a1, b1);
    serve(0, 2, 0, 32'h0, 2'b00, 1'b0, 1'b0);
    serve(1, 37, 3, 32'h36243624, 2'b00, 1'b1, 1'b0);
    @(negedge clk);
    chk("t1_res_valid_pulse", res_valid, 1'b0);
    chk("t1_done_pulse", done, 1'b0);
    chk("t1_a_bus_hold", a_bus, a1);
    chk("t1_res_hold", res, 32'h36243624);

    // All three modes, with stray start and done_sa2 during single
    do_start(2'b11, a2, b2);
    serve(0, 0, 0, 32'h0, 2'b00, 1'b0, 1'b0);
    serve(1, 37, 3, 32'h11223344, 2'b00, 1'b0, 1'b1);
    serve(2, 16, 3, 32'h55667788, 2'b01, 1'b0, 1'b0);
    serve(3, 28, 3, 32'h99aabbcc, 2'b10, 1'b1, 1'b0);
    @(negedge clk);
    chk("t2_res_valid_pulse", res_valid, 1'b0);
    chk("t2_a_bus_hold", a_bus, a2);
    chk("t2_b_bus_hold", b_bus, b2);
    chk("t2_res_hold", res, 32'h99aabbcc);

    // Reset in the middle of sa3
    do_start(2'b11, a1, b2);
    serve(0, 1, 0, 32'h0, 2'b00, 1'b0, 1'b0);
    serve(1, 3, 3, 32'h01020304, 2'b00, 1'b0, 1'b0);
    begin
      int w = 0;
      while (!active_sa3 && w < 60) begin w++; @(negedge clk); end
    end
    chk("t3_sa3_seen", active_sa3, 1'b1);
    repeat (5) @(negedge clk);
    chk("t3_sa3_before_rst", active_sa3, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("t3_rst_sa3", active_sa3, 1'b0);
    chk("t3_rst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_start(2'b10, a2, b1);
    serve(0, 0, 0, 32'h0, 2'b00, 1'b0, 1'b0);
    serve(3, 5, 3, 32'hdeadbeef, 2'b10, 1'b1, 1'b0);
    @(negedge clk);

`ifdef COMP_SEQ_TIMEOUT_EN
    // Watchdog: done_single never returns
    do_start(2'b00, a1, b1);
    serve(0, 1, 0, 32'h0, 2'b00, 1'b0, 1'b0);
    begin
      int w   = 0;
      int len = 0;
      while (!active_single && w < 60) begin w++; @(negedge clk); end
      chk("t4_single_seen", active_single, 1'b1);
      while (active_single && len < 100) begin len++; @(negedge clk); end
      $display("timeout: active_single held %0d cycles", len);
      chk("t4_timeout_len", len, 64);
      chk("t4_err", err, 1'b1);
      chk("t4_done", done, 1'b1);
      chk("t4_no_res_valid", res_valid, 1'b0);
      chk("t4_busy", busy, 1'b0);
    end
    @(negedge clk);
    do_start(2'b00, a2, b2);
    chk("t4_err_cleared", err, 1'b0);
    serve(0, 0, 0, 32'h0, 2'b00, 1'b0, 1'b0);
    serve(1, 2, 3, 32'hcafef00d, 2'b00, 1'b1, 1'b0);
    @(negedge clk);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
